// File: rtl/ram_stream_loader.sv
// ram_stream_loader: packs a byte stream, or zero-fills, into one of
// several word-wide RAM write ports under a simple command handshake.
module ram_stream_loader #(
  parameter  int NUM_CHANNELS = 3,
  parameter  int ADDR_WIDTH   = 10,
  parameter  int WORD_BYTES   = 1,
  localparam int DATA_WIDTH   = 8 * WORD_BYTES,
  localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int LEN_W = ADDR_WIDTH + 1
) (
  input  logic                    clock,
  input  logic                    resetN,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [CH_W-1:0]         cmd_chan,
  input  logic                    cmd_mode,
  input  logic [LEN_W-1:0]        cmd_len,
  input  logic                    cmd_abort,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [7:0]              s_data,
  output logic [NUM_CHANNELS-1:0] wr_en,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [LEN_W-1:0]        words_written
);

  localparam int LANE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORD_BYTES - 1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_WIDTH);
  localparam logic [NUM_CHANNELS-1:0] ONE = NUM_CHANNELS'(1);

  typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} state_t;

  state_t                state;
  logic [CH_W-1:0]       chan;
  logic [LEN_W-1:0]      len;
  logic [LANE_W-1:0]     lane;
  logic [DATA_WIDTH-1:0] word_buf;
  logic [DATA_WIDTH-1:0] word_next;
  logic [LEN_W-1:0]      ww_next;
  logic                  cmd_fire;
  logic                  byte_fire;
  logic                  word_last;
  logic                  chan_bad;
  logic                  len_bad;
  logic                  all_written;

  assign cmd_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign cmd_fire    = cmd_valid && cmd_ready;
  assign byte_fire   = s_valid && s_ready;
  assign word_last   = (lane == LAST_LANE);
  assign ww_next     = words_written + LEN_W'(1);
  assign chan_bad    = int'(cmd_chan) >= NUM_CHANNELS;
  assign len_bad     = cmd_len > MAX_LEN;
  assign all_written = (words_written == len);

  // Incoming byte merged into its little-endian lane
  always_comb begin
    word_next = word_buf;
    word_next[int'(lane)*8 +: 8] = s_data;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state         <= IDLE;
      chan          <= '0;
      len           <= '0;
      lane          <= '0;
      word_buf      <= '0;
      s_ready       <= 1'b0;
      wr_en         <= '0;
      wr_addr       <= '0;
      wr_data       <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
      words_written <= '0;
    end else begin
      wr_en <= '0;
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            chan          <= cmd_chan;
            len           <= cmd_len;
            lane          <= '0;
            words_written <= '0;
            if (chan_bad || len_bad) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (cmd_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (cmd_mode) begin
              state <= FILL;
            end else begin
              state   <= LOAD;
              s_ready <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (cmd_abort || all_written) begin
            state   <= DONE;
            done    <= 1'b1;
            s_ready <= 1'b0;
            lane    <= '0;
          end else if (byte_fire) begin
            word_buf <= word_next;
            if (word_last) begin
              lane          <= '0;
              wr_en         <= ONE << chan;
              wr_addr       <= words_written[ADDR_WIDTH-1:0];
              wr_data       <= word_next;
              words_written <= ww_next;
              if (ww_next == len) s_ready <= 1'b0;
            end else begin
              lane <= lane + LANE_W'(1);
            end
          end
        end
        FILL: begin
          if (cmd_abort || all_written) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            wr_en         <= ONE << chan;
            wr_addr       <= words_written[ADDR_WIDTH-1:0];
            wr_data       <= '0;
            words_written <= ww_next;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_stream_loader.sv
// Bench for ram_stream_loader: directed scenarios plus random commands
// checked against a word-level model of the loader.
module tb_ram_stream_loader;

  localparam int NC = 3;
  localparam int AW = 4;
  localparam int WB = 2;

  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_chan = '0;
  logic        cmd_mode = 1'b0;
  logic [4:0]  cmd_len = '0;
  logic        cmd_abort = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = '0;
  logic [2:0]  wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [4:0]  words_written;

  int vectors = 0;
  int miscompares = 0;

  ram_stream_loader #(
    .NUM_CHANNELS(NC),
    .ADDR_WIDTH(AW),
    .WORD_BYTES(WB)
  ) dut (
    .clock(clock),
    .resetN(resetN),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_chan(cmd_chan),
    .cmd_mode(cmd_mode),
    .cmd_len(cmd_len),
    .cmd_abort(cmd_abort),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy(busy),
    .done(done),
    .err(err),
    .words_written(words_written)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          c;
    logic [2:0]  en;
    logic [3:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t        wq[$];
  int         acc_c[$];
  logic [7:0] stream_q[$];
  int         cyc = 0;
  int         done_n = 0;
  int         done_c = 0;
  logic       done_err;
  logic [4:0] done_ww;

  always @(negedge clock) begin
    wr_t w;
    cyc++;
    if (wr_en !== 3'b000) begin
      w.c = cyc; w.en = wr_en; w.a = wr_addr; w.d = wr_data;
      wq.push_back(w);
    end
    if (s_valid && s_ready) acc_c.push_back(cyc);
    if (done) begin
      done_n++;
      done_c = cyc;
      done_err = err;
      done_ww = words_written;
    end
  end

  // gap: 0 = stream always valid, 1 = toggle, 2 = random
  task automatic run_cmd(input logic [1:0] ch, input logic md,
                         input logic [4:0] ln, input int gap,
                         input int abort_at, input bit ramp);
    int n = 0;
    bit tog = 1'b1;
    bit fin = 1'b0;
    bit aborted = 1'b0;
    wq.delete(); acc_c.delete(); stream_q.delete();
    done_n = 0;
    for (int i = 0; i < 40; i++)
      stream_q.push_back(ramp ? 8'(i + 1) : 8'($urandom));
    @(posedge clock); #1;
    cmd_valid = 1'b1; cmd_chan = ch; cmd_mode = md; cmd_len = ln;
    @(negedge clock);
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready);
    end
    for (int t = 0; t < 400 && !fin; t++) begin
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      cmd_abort = 1'b0;
      if (abort_at >= 0 && n == abort_at && !aborted) begin
        cmd_abort = 1'b1;
        aborted = 1'b1;
      end
      case (gap)
        0: s_valid = 1'b1;
        1: begin s_valid = tog; tog = !tog; end
        default: s_valid = 1'($urandom_range(0, 1));
      endcase
      s_data = stream_q[n % 40];
      @(negedge clock);
      if (s_valid && s_ready) n++;
      if (done) fin = 1'b1;
    end
    @(posedge clock); #1;
    s_valid = 1'b0; cmd_abort = 1'b0;
    vectors++;
    if (!fin) begin
      miscompares++;
      $display("FAIL cmd_timeout: done never seen, got 0 want 1");
    end
  endtask

  task automatic test_reset;
    logic [40:0] outs;
    resetN = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    outs = {wr_en, busy, done, err, s_ready, words_written, wr_addr, wr_data};
    vectors++;
    if (outs !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 0", outs);
    end
    @(posedge clock); #1;
    resetN = 1'b1;
    @(negedge clock);
    vectors++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got ready=%b busy=%b want 1 0",
               cmd_ready, busy);
    end
  endtask

  task automatic test_load_basic;
    logic [15:0] exp_d[3];
    exp_d[0] = 16'h0201; exp_d[1] = 16'h0403; exp_d[2] = 16'h0605;
    run_cmd(2'd1, 1'b0, 5'd3, 0, -1, 1'b1);
    vectors++;
    if (wq.size() != 3 || acc_c.size() != 6) begin
      miscompares++;
      $display("FAIL load_count: got %0d writes %0d bytes want 3 6",
               wq.size(), acc_c.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (wq[i].en !== 3'b010 || wq[i].a !== 4'(i) ||
            wq[i].d !== exp_d[i] || wq[i].c != acc_c[2*i+1] + 1) begin
          miscompares++;
          $display("FAIL load_word%0d: got en=%b a=%0d d=%h c=%0d want 010 %0d %h %0d",
                   i, wq[i].en, wq[i].a, wq[i].d, wq[i].c, i, exp_d[i],
                   acc_c[2*i+1] + 1);
        end
      end
      vectors++;
      if (done_c != wq[2].c + 1 || done_ww !== 5'd3 || done_err !== 1'b0) begin
        miscompares++;
        $display("FAIL load_done: got c=%0d ww=%0d err=%b want %0d 3 0",
                 done_c, done_ww, done_err, wq[2].c + 1);
      end
    end
  endtask

  task automatic test_fill;
    run_cmd(2'd2, 1'b1, 5'd16, 0, -1, 1'b0);
    vectors++;
    if (wq.size() != 16 || acc_c.size() != 0) begin
      miscompares++;
      $display("FAIL fill_count: got %0d writes %0d bytes want 16 0",
               wq.size(), acc_c.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        vectors++;
        if (wq[i].en !== 3'b100 || wq[i].a !== 4'(i) ||
            wq[i].d !== 16'h0 || wq[i].c != wq[0].c + i) begin
          miscompares++;
          $display("FAIL fill_word%0d: got en=%b a=%0d d=%h c=%0d want 100 %0d 0 %0d",
                   i, wq[i].en, wq[i].a, wq[i].d, wq[i].c, i, wq[0].c + i);
        end
      end
      vectors++;
      if (done_c != wq[15].c + 1 || done_ww !== 5'd16 || done_n != 1) begin
        miscompares++;
        $display("FAIL fill_done: got c=%0d ww=%0d n=%0d want %0d 16 1",
                 done_c, done_ww, done_n, wq[15].c + 1);
      end
    end
  endtask

  task automatic test_reject;
    logic [1:0] chs[3];
    logic [4:0] lns[3];
    logic       errs[3];
    chs[0] = 2'd1; lns[0] = 5'd0;  errs[0] = 1'b0;
    chs[1] = 2'd1; lns[1] = 5'd17; errs[1] = 1'b1;
    chs[2] = 2'd3; lns[2] = 5'd2;  errs[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      run_cmd(chs[k], 1'b0, lns[k], 0, -1, 1'b0);
      vectors++;
      if (done_n != 1 || done_err !== errs[k] || wq.size() != 0 ||
          acc_c.size() != 0 || done_ww !== 5'd0) begin
        miscompares++;
        $display("FAIL reject%0d: got n=%0d err=%b wr=%0d by=%0d ww=%0d want 1 %b 0 0 0",
                 k, done_n, done_err, wq.size(), acc_c.size(), done_ww, errs[k]);
      end
    end
  endtask

  task automatic test_gapped;
    run_cmd(2'd0, 1'b0, 5'd2, 1, -1, 1'b0);
    vectors++;
    if (wq.size() != 2 || acc_c.size() != 4) begin
      miscompares++;
      $display("FAIL gap_count: got %0d writes %0d bytes want 2 4",
               wq.size(), acc_c.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (wq[i].c != acc_c[2*i+1] + 1 || wq[i].a !== 4'(i) ||
            wq[i].en !== 3'b001 ||
            wq[i].d !== {stream_q[2*i+1], stream_q[2*i]}) begin
          miscompares++;
          $display("FAIL gap_word%0d: got c=%0d a=%0d d=%h want %0d %0d %h",
                   i, wq[i].c, wq[i].a, wq[i].d, acc_c[2*i+1] + 1, i,
                   {stream_q[2*i+1], stream_q[2*i]});
        end
      end
    end
  endtask

  task automatic test_abort;
    run_cmd(2'd1, 1'b0, 5'd4, 0, 3, 1'b0);
    vectors++;
    if (wq.size() != 1 || done_ww !== 5'd1 || done_err !== 1'b0 ||
        done_n != 1) begin
      miscompares++;
      $display("FAIL abort_result: got wr=%0d ww=%0d err=%b n=%0d want 1 1 0 1",
               wq.size(), done_ww, done_err, done_n);
    end else begin
      vectors++;
      if (wq[0].a !== 4'd0 || wq[0].d !== {stream_q[1], stream_q[0]}) begin
        miscompares++;
        $display("FAIL abort_word: got a=%0d d=%h want 0 %h",
                 wq[0].a, wq[0].d, {stream_q[1], stream_q[0]});
      end
    end
    run_cmd(2'd0, 1'b1, 5'd2, 0, -1, 1'b0);
    vectors++;
    if (wq.size() != 2 || done_ww !== 5'd2) begin
      miscompares++;
      $display("FAIL abort_next: got wr=%0d ww=%0d want 2 2", wq.size(), done_ww);
    end
  endtask

  task automatic test_reset_mid_fill;
    logic [40:0] outs;
    @(posedge clock); #1;
    cmd_valid = 1'b1; cmd_chan = 2'd2; cmd_mode = 1'b1; cmd_len = 5'd16;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    repeat (5) @(posedge clock);
    #3;
    vectors++;
    if (wr_en !== 3'b100 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midfill_active: got en=%b busy=%b want 100 1", wr_en, busy);
    end
    resetN = 1'b0;
    #1;
    outs = {wr_en, busy, done, err, s_ready, words_written, wr_addr, wr_data};
    vectors++;
    if (outs !== '0) begin
      miscompares++;
      $display("FAIL midfill_async_reset: got %h want 0", outs);
    end
    repeat (2) @(posedge clock);
    #1;
    resetN = 1'b1;
    @(negedge clock);
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midfill_release: got ready=%b want 1", cmd_ready);
    end
    test_load_basic();
  endtask

  task automatic test_random;
    logic [1:0]  ch;
    logic [4:0]  ln;
    logic        md;
    logic        exp_err;
    int          exp_n;
    int          exp_acc;
    int          exp_c;
    int          r;
    logic [15:0] exp_d;
    for (int k = 0; k < 30; k++) begin
      md = 1'($urandom_range(0, 1));
      ch = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r  = $urandom_range(0, 9);
      ln = (r == 0) ? 5'd0 : (r == 1) ? 5'd17 : 5'($urandom_range(1, 16));
      run_cmd(ch, md, ln, $urandom_range(0, 2), -1, 1'b0);
      exp_err = (ch >= 2'd3) || (ln > 5'd16);
      exp_n   = exp_err ? 0 : int'(ln);
      exp_acc = md ? 0 : 2 * exp_n;
      vectors++;
      if (done_n != 1 || done_err !== exp_err || done_ww !== 5'(exp_n)) begin
        miscompares++;
        $display("FAIL rnd%0d_done: got n=%0d err=%b ww=%0d want 1 %b %0d",
                 k, done_n, done_err, done_ww, exp_err, exp_n);
      end
      vectors++;
      if (wq.size() != exp_n || acc_c.size() != exp_acc) begin
        miscompares++;
        $display("FAIL rnd%0d_count: got %0d writes %0d bytes want %0d %0d",
                 k, wq.size(), acc_c.size(), exp_n, exp_acc);
      end else if (exp_n > 0) begin
        for (int i = 0; i < exp_n; i++) begin
          exp_d = md ? 16'h0 : {stream_q[2*i+1], stream_q[2*i]};
          exp_c = md ? wq[0].c + i : acc_c[2*i+1] + 1;
          vectors++;
          if (wq[i].en !== 3'(1 << ch) || wq[i].a !== 4'(i) ||
              wq[i].d !== exp_d || wq[i].c != exp_c) begin
            miscompares++;
            $display("FAIL rnd%0d_word%0d: got en=%b a=%0d d=%h c=%0d want %b %0d %h %0d",
                     k, i, wq[i].en, wq[i].a, wq[i].d, wq[i].c,
                     3'(1 << ch), i, exp_d, exp_c);
          end
        end
        vectors++;
        if (done_c != wq[exp_n-1].c + 1) begin
          miscompares++;
          $display("FAIL rnd%0d_done_time: got %0d want %0d",
                   k, done_c, wq[exp_n-1].c + 1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_fill();
    test_reject();
    test_gapped();
    test_abort();
    test_reset_mid_fill();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

endmodule
